// File: rtl/fmul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fmul_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  typedef enum logic {RND_RZ, RND_RNE} rnd_mode_t;

  // Special-case result chosen in stage 1 and carried down the pipe
  typedef enum logic [1:0] {SPEC_NONE, SPEC_NAN, SPEC_INF, SPEC_ZERO} spec_t;

  typedef struct packed {
    logic      sign;
    rnd_mode_t rnd;
    spec_t     spec;
  } op_ctrl_t;

  typedef struct packed {
    logic error;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  localparam int unsigned CANON_W = 64;

  // Canonical quiet NaN, right-aligned; callers truncate to their word width
  function automatic logic [CANON_W-1:0] canon_nan(input int unsigned exp_w,
                                                   input int unsigned frac_w);
    logic [CANON_W-1:0] one;
    one = CANON_W'(1);
    return (((one << exp_w) - one) << frac_w) | (one << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalise the raw mantissa product by one place and apply RZ/RNE rounding.
module fmul_round
  import fmul_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic [2*FRAC_W+1:0]     prod,
  input  logic signed [EXP_W+1:0] exp_in,
  input  rnd_mode_t               rnd,
  output logic [FRAC_W+1:0]       mant_c,
  output logic signed [EXP_W+1:0] exp_c
);

  localparam int unsigned PW = 2*FRAC_W+2;
  localparam int unsigned MW = FRAC_W+1;
  localparam int unsigned EW = EXP_W+2;

  logic [MW-1:0] mant;
  logic          guard;
  logic          sticky;
  logic          inc;

  // Product lies in [1,4): top bit set means one extra integer bit
  always_comb begin
    mant   = prod[PW-2 -: MW];
    guard  = prod[FRAC_W-1];
    sticky = |prod[FRAC_W-2:0];
    exp_c  = exp_in;
    if (prod[PW-1]) begin
      mant   = prod[PW-1 -: MW];
      guard  = prod[FRAC_W];
      sticky = |prod[FRAC_W-1:0];
      exp_c  = exp_in + EW'(1);
    end
    inc    = (rnd == RND_RNE) && guard && (sticky || mant[0]);
    mant_c = {1'b0, mant} + (FRAC_W+2)'(inc);
  end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined FP multiplier with valid/ready handshake.
// Optional sticky flag accumulator enabled by defining FMUL_STICKY_FLAGS_EN.
module fmul_pipe
  import fmul_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned BIAS   = 2**(EXP_W-1)-1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  input  logic                    in_rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_res,
  output logic                    out_error,
  output logic                    out_overflow,
  output logic                    out_underflow
`ifdef FMUL_STICKY_FLAGS_EN
  ,
  input  logic                    flags_clr,
  output logic [2:0]              sticky_flags
`endif
);

  localparam int unsigned W  = 1+EXP_W+FRAC_W;
  localparam int unsigned EW = EXP_W+2;
  localparam int unsigned PW = 2*FRAC_W+2;
  localparam int unsigned MW = FRAC_W+2;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [FRAC_W-1:0] f);
    if (e == '0) return ZERO;
    if (e == '1) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  // Stage 1: classify, exponent sum, mantissa product
  fp_class_t              ca, cb;
  op_ctrl_t               ctrl_d;
  logic signed [EW-1:0]   exp_sum_d;
  logic [PW-1:0]          prod_d;

  always_comb begin
    ca = classify(in_a[W-2 -: EXP_W], in_a[FRAC_W-1:0]);
    cb = classify(in_b[W-2 -: EXP_W], in_b[FRAC_W-1:0]);
    ctrl_d.sign = in_a[W-1] ^ in_b[W-1];
    ctrl_d.rnd  = rnd_mode_t'(in_rnd);
    ctrl_d.spec = SPEC_NONE;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF))
      ctrl_d.spec = SPEC_NAN;
    else if (ca == INF || cb == INF)
      ctrl_d.spec = SPEC_INF;
    else if (ca == ZERO || cb == ZERO)
      ctrl_d.spec = SPEC_ZERO;
    exp_sum_d = signed'(EW'(in_a[W-2 -: EXP_W]) + EW'(in_b[W-2 -: EXP_W]) - EW'(BIAS));
    prod_d    = PW'({1'b1, in_a[FRAC_W-1:0]}) * PW'({1'b1, in_b[FRAC_W-1:0]});
  end

  logic                 v1;
  op_ctrl_t             ctrl1;
  logic signed [EW-1:0] exp1;
  logic [PW-1:0]        prod1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      ctrl1 <= '0;
      exp1  <= '0;
      prod1 <= '0;
    end else if (en) begin
      v1    <= in_valid;
      ctrl1 <= ctrl_d;
      exp1  <= exp_sum_d;
      prod1 <= prod_d;
    end
  end

  // Stage 2: normalise and round
  logic [MW-1:0]        mant_rnd;
  logic signed [EW-1:0] exp_rnd;

  fmul_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .prod   (prod1),
    .exp_in (exp1),
    .rnd    (ctrl1.rnd),
    .mant_c (mant_rnd),
    .exp_c  (exp_rnd)
  );

  logic                 v2;
  op_ctrl_t             ctrl2;
  logic [MW-1:0]        mant2;
  logic signed [EW-1:0] exp2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      ctrl2 <= '0;
      mant2 <= '0;
      exp2  <= '0;
    end else if (en) begin
      v2    <= v1;
      ctrl2 <= ctrl1;
      mant2 <= mant_rnd;
      exp2  <= exp_rnd;
    end
  end

  // Stage 3: rounding carry, range check, special-case override
  logic [FRAC_W-1:0]    frac_n;
  logic signed [EW-1:0] exp_n;
  logic [W-1:0]         res_d;
  fp_flags_t            flags_d;

  always_comb begin
    frac_n  = mant2[FRAC_W-1:0];
    exp_n   = exp2;
    if (mant2[FRAC_W+1]) begin
      frac_n = mant2[FRAC_W:1];
      exp_n  = exp2 + EW'(1);
    end
    res_d   = {ctrl2.sign, exp_n[EXP_W-1:0], frac_n};
    flags_d = '0;
    case (ctrl2.spec)
      SPEC_NAN: begin
        res_d         = W'(canon_nan(EXP_W, FRAC_W));
        flags_d.error = 1'b1;
      end
      SPEC_INF:  res_d = {ctrl2.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      SPEC_ZERO: res_d = {ctrl2.sign, {(W-1){1'b0}}};
      default: begin
        if (exp_n >= signed'(EW'(2**EXP_W - 1))) begin
          flags_d.overflow = 1'b1;
          if (ctrl2.rnd == RND_RNE)
            res_d = {ctrl2.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          else
            res_d = {ctrl2.sign, EXP_W'(2**EXP_W - 2), {FRAC_W{1'b1}}};
        end else if (exp_n <= signed'(EW'(0))) begin
          flags_d.underflow = 1'b1;
          res_d             = {ctrl2.sign, {(W-1){1'b0}}};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_res       <= '0;
      out_error     <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (en) begin
      out_valid     <= v2;
      out_res       <= res_d;
      out_error     <= flags_d.error;
      out_overflow  <= flags_d.overflow;
      out_underflow <= flags_d.underflow;
    end
  end

`ifdef FMUL_STICKY_FLAGS_EN
  // Accumulate flags of consumed results; a new set wins over a clear
  logic [2:0] flag_set;
  assign flag_set = (out_valid && out_ready) ? {out_error, out_overflow, out_underflow} : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_flags <= 3'b000;
    else if (flags_clr)
      sticky_flags <= flag_set;
    else
      sticky_flags <= sticky_flags | flag_set;
  end
`endif

endmodule
